trace_readout_er2: RTL and testbench

//  Readout end of the on-chip logic analyser: responder on the ER2 JTAG user-register path.

---
 rtl/trace_readout_pkg.sv | 22 ++
 rtl/er2_shift_reg.sv | 36 +++
 rtl/trace_readout_er2.sv | 147 ++++++++++++++
 tb/tb_trace_readout_er2.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_readout_pkg.sv
// Shared opcodes, FSM encoding and sizing helpers for the ER2 trace readout responder.
package trace_readout_pkg;

    localparam int CMD_W = 16;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_STATUS  = 2'b01;
    localparam logic [1:0] OP_SETADDR = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        FETCH    = 2'b01,
        WAIT     = 2'b10,
        SHIFTING = 2'b11
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/er2_shift_reg.sv
// Command capture register plus response shift register for the ER2 path.
// A parallel load of the response register always beats a shift in the same cycle.
module er2_shift_reg
    import trace_readout_pkg::*;
#(
    parameter int SRW = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_shift,
    input  logic             shift_bit,
    input  logic             sr_shift,
    input  logic             sr_load,
    input  logic [SRW-1:0]   sr_load_val,
    output logic [CMD_W-1:0] cmd_sr,
    output logic [SRW-1:0]   sr
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_sr <= '0;
            sr     <= '0;
        end else begin
            // Host shifts LSB first, so new bits enter at the top.
            if (cmd_shift) begin
                cmd_sr <= {shift_bit, cmd_sr[CMD_W-1:1]};
            end
            if (sr_load) begin
                sr <= sr_load_val;
            end else if (sr_shift) begin
                sr <= {1'b0, sr[SRW-1:1]};
            end
        end
    end

endmodule

// File: rtl/trace_readout_er2.sv
// Logic-analyser readout responder on the ER2 JTAG user register: decodes host commands
// and returns capture status or trace-RAM words, prefetching the next word automatically.
module trace_readout_er2
    import trace_readout_pkg::*;
#(
    parameter int TRACE_W = 6,
    parameter int ADDR_W  = 9
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ip_enable,
    input  logic               jce2,
    input  logic               jshift_stb,
    input  logic               jtdi,
    input  logic               jupdate_stb,
    output logic               er2_tdo,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [TRACE_W-1:0] rd_data,
    input  logic [ADDR_W-1:0]  cap_wr_ptr,
    input  logic               cap_wrapped,
    input  logic               cap_triggered,
    output logic               underrun
);

    localparam int SRW   = max_int(TRACE_W, ADDR_W + 2);
    localparam int CNT_W = (TRACE_W > 1) ? $clog2(TRACE_W) : 1;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [CMD_W-1:0] cmd_sr;
    logic [SRW-1:0]   sr;
    logic [SRW-1:0]   sr_load_val;
    logic [1:0]       opcode;
    logic             shift_act;
    logic             upd_act;
    logic             shift_ok;
    logic             cmd_upd;
    logic             read_gap;
    logic             last_bit;
    logic             sr_load;
    logic             sr_shift;
    logic             unused_cmd;

    assign shift_act  = jshift_stb & jce2 & ip_enable;
    assign upd_act    = jupdate_stb & jce2 & ip_enable;
    assign shift_ok   = shift_act & ~upd_act;
    assign opcode     = cmd_sr[CMD_W-1 -: 2];
    assign cmd_upd    = upd_act & (opcode != OP_NOP);
    assign read_gap   = (state == FETCH) || (state == WAIT);
    assign last_bit   = (bit_cnt == CNT_W'(TRACE_W - 1));
    assign unused_cmd = &{1'b0, cmd_sr};

    // While a word is in flight the host sees zeros, whatever stale bits sr still holds.
    assign er2_tdo = ip_enable & sr[0] & ~read_gap;

    always_comb begin
        sr_load     = 1'b0;
        sr_load_val = '0;
        sr_shift    = 1'b0;
        if (upd_act && (opcode == OP_STATUS)) begin
            sr_load     = 1'b1;
            sr_load_val = SRW'({cap_wr_ptr, cap_wrapped, cap_triggered});
        end else if ((state == WAIT) && !cmd_upd) begin
            sr_load     = 1'b1;
            sr_load_val = SRW'(rd_data);
        end else if (shift_ok && !read_gap) begin
            sr_shift = 1'b1;
        end
    end

    er2_shift_reg #(
        .SRW(SRW)
    ) u_shift_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_shift  (shift_ok),
        .shift_bit  (jtdi),
        .sr_shift   (sr_shift),
        .sr_load    (sr_load),
        .sr_load_val(sr_load_val),
        .cmd_sr     (cmd_sr),
        .sr         (sr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            rd_addr  <= '0;
            rd_en    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            rd_en <= 1'b0;
            if (cmd_upd) begin
                case (opcode)
                    OP_STATUS: begin
                        state <= IDLE;
                    end
                    OP_SETADDR: begin
                        rd_addr  <= cmd_sr[ADDR_W-1:0];
                        bit_cnt  <= '0;
                        underrun <= 1'b0;
                        state    <= IDLE;
                    end
                    default: begin
                        state <= FETCH;
                        rd_en <= 1'b1;
                    end
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    FETCH: begin
                        state <= WAIT;
                        if (shift_ok) begin
                            underrun <= 1'b1;
                        end
                    end
                    WAIT: begin
                        bit_cnt <= '0;
                        state   <= SHIFTING;
                        if (shift_ok) begin
                            underrun <= 1'b1;
                        end
                    end
                    default: begin
                        // Last bit of the word kicks off the fetch of the next address.
                        if (shift_ok) begin
                            if (last_bit) begin
                                bit_cnt <= '0;
                                rd_addr <= rd_addr + ADDR_W'(1);
                                rd_en   <= 1'b1;
                                state   <= FETCH;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trace_readout_er2.sv
// Directed bench for trace_readout_er2: host-level model of the ER2 readout protocol
// compared every cycle, plus literal expectations for the characteristic scenarios.
module tb_trace_readout_er2;

    localparam int TRACE_W = 6;
    localparam int ADDR_W  = 9;
    localparam int DEPTH   = 512;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               ip_enable;
    logic               jce2;
    logic               jshift_stb;
    logic               jtdi;
    logic               jupdate_stb;
    logic               er2_tdo;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [TRACE_W-1:0] rd_data = '0;
    logic [ADDR_W-1:0]  cap_wr_ptr;
    logic               cap_wrapped;
    logic               cap_triggered;
    logic               underrun;

    logic [TRACE_W-1:0] ram [0:DEPTH-1];

    int cyc       = 0;
    int rd_pulses = 0;
    int n_cmp     = 0;
    int n_fail    = 0;
    bit chk_en    = 1'b0;

    // Host-level model: what the host must observe, tracked per command and per shifted bit.
    logic [15:0] m_cmd;
    logic [10:0] m_img;
    bit          m_known;
    bit          m_reading;
    int          m_addr;
    int          m_bitpos;
    int          m_ready_at;
    bit          m_underrun;

    trace_readout_er2 #(
        .TRACE_W(TRACE_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ip_enable    (ip_enable),
        .jce2         (jce2),
        .jshift_stb   (jshift_stb),
        .jtdi         (jtdi),
        .jupdate_stb  (jupdate_stb),
        .er2_tdo      (er2_tdo),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .cap_wr_ptr   (cap_wr_ptr),
        .cap_wrapped  (cap_wrapped),
        .cap_triggered(cap_triggered),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data   <= ram[rd_addr];
            rd_pulses <= rd_pulses + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic exp_tdo();
        if (!ip_enable) return 1'b0;
        if (m_reading) return (cyc < m_ready_at) ? 1'b0 : ram[m_addr][m_bitpos];
        return m_img[0];
    endfunction

    task automatic model_reset();
        m_cmd      = '0;
        m_img      = '0;
        m_known    = 1'b1;
        m_reading  = 1'b0;
        m_addr     = 0;
        m_bitpos   = 0;
        m_ready_at = 0;
        m_underrun = 1'b0;
    endtask

    task automatic model_shift(input logic d);
        m_cmd = {d, m_cmd[15:1]};
        if (m_reading) begin
            if (cyc <= m_ready_at) begin
                m_underrun = 1'b1;
            end else begin
                m_bitpos++;
                if (m_bitpos == TRACE_W) begin
                    m_bitpos   = 0;
                    m_addr     = (m_addr + 1) % DEPTH;
                    m_ready_at = cyc + 2;
                end
            end
        end else begin
            m_img = m_img >> 1;
        end
    endtask

    task automatic model_update();
        case (m_cmd[15:14])
            2'b01: begin
                m_reading = 1'b0;
                m_known   = 1'b1;
                m_img     = {cap_wr_ptr, cap_wrapped, cap_triggered};
            end
            2'b10: begin
                if (m_reading) m_known = 1'b0;
                m_reading  = 1'b0;
                m_addr     = int'(m_cmd[8:0]);
                m_underrun = 1'b0;
            end
            2'b11: begin
                m_reading  = 1'b1;
                m_bitpos   = 0;
                m_ready_at = cyc + 2;
            end
            default: ;
        endcase
    endtask

    // One host shift: strobe for a cycle, capture what the host sees, then idle 3 clocks.
    task automatic do_shift(input logic d, input bit immediate, output logic got);
        if (!immediate) begin
            @(posedge clk);
            #1;
        end
        jtdi       = d;
        jshift_stb = 1'b1;
        @(negedge clk);
        got = er2_tdo;
        @(posedge clk);
        #1;
        jshift_stb = 1'b0;
        if (ip_enable && jce2) model_shift(d);
        repeat (3) @(posedge clk);
    endtask

    task automatic do_update(input logic with_shift, input logic d);
        @(posedge clk);
        #1;
        jupdate_stb = 1'b1;
        jshift_stb  = with_shift;
        jtdi        = d;
        @(posedge clk);
        #1;
        jupdate_stb = 1'b0;
        jshift_stb  = 1'b0;
        if (ip_enable && jce2) model_update();
    endtask

    task automatic send_cmd(input logic [15:0] c);
        logic b;
        for (int i = 0; i < 16; i++) do_shift(c[i], 1'b0, b);
    endtask

    task automatic read_bits(input int n, output logic [TRACE_W-1:0] w);
        logic b;
        w = '0;
        for (int i = 0; i < n; i++) begin
            do_shift(1'b0, 1'b0, b);
            w[i] = b;
        end
    endtask

    initial begin
        logic [10:0]        st;
        logic [TRACE_W-1:0] w;
        logic [TRACE_W-1:0] w2;
        logic               b;
        int                 p0;

        for (int i = 0; i < DEPTH; i++) ram[i] = TRACE_W'((i * 37 + 11) ^ (i >> 3));
        ram[0]   = 6'h13;
        ram[1]   = 6'h2A;
        ram[511] = 6'h2D;

        reset_n       = 1'b0;
        ip_enable     = 1'b1;
        jce2          = 1'b1;
        jshift_stb    = 1'b0;
        jtdi          = 1'b1;
        jupdate_stb   = 1'b0;
        cap_wr_ptr    = '0;
        cap_wrapped   = 1'b0;
        cap_triggered = 1'b0;
        model_reset();

        fork
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    chk("rd_addr", 32'(rd_addr), 32'(m_addr));
                    chk("underrun", 32'(underrun), 32'(m_underrun));
                    chk("rd_en", 32'(rd_en), 32'(m_reading && (cyc == m_ready_at - 2)));
                    if (!ip_enable || m_reading || m_known)
                        chk("er2_tdo", 32'(er2_tdo), 32'(exp_tdo()));
                end
            end
        join_none

        // Reset held while the shift strobe toggles
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            jshift_stb = ~jshift_stb;
            @(negedge clk);
            chk("reset_tdo", 32'(er2_tdo), 32'h0);
            chk("reset_rd_en", 32'(rd_en), 32'h0);
            chk("reset_rd_addr", 32'(rd_addr), 32'h0);
            chk("reset_underrun", 32'(underrun), 32'h0);
        end
        @(posedge clk);
        #1;
        jshift_stb = 1'b0;
        reset_n    = 1'b1;
        chk_en     = 1'b1;

        // STATUS readout
        cap_wr_ptr    = 9'h1A5;
        cap_wrapped   = 1'b1;
        cap_triggered = 1'b1;
        send_cmd(16'h4000);
        do_update(1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            do_shift(1'b0, 1'b0, b);
            st[i] = b;
        end
        chk("status_bits", 32'(st), 32'(11'b11010010111));

        // SET_ADDR to the last word, READ across the wrap
        send_cmd(16'h81FF);
        do_update(1'b0, 1'b0);
        chk("setaddr_511", 32'(rd_addr), 32'h1FF);
        send_cmd(16'hC000);
        do_update(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        read_bits(TRACE_W, w);
        chk("word_511", 32'(w), 32'h2D);
        chk("wrap_addr0", 32'(rd_addr), 32'h0);
        read_bits(TRACE_W, w);
        chk("word_0", 32'(w), 32'h13);
        chk("next_addr1", 32'(rd_addr), 32'h1);

        // Shift one clock after READ: underrun, zero out, word still delivered
        send_cmd(16'h8005);
        do_update(1'b0, 1'b0);
        send_cmd(16'hC000);
        do_update(1'b0, 1'b0);
        do_shift(1'b1, 1'b1, b);
        chk("underrun_bit", 32'(b), 32'h0);
        chk("underrun_set", 32'(underrun), 32'h1);
        read_bits(TRACE_W, w);
        chk("word_after_underrun", 32'(w), 32'(ram[5]));
        send_cmd(16'h8000);
        do_update(1'b0, 1'b0);
        chk("underrun_cleared", 32'(underrun), 32'h0);

        // Shift and update in the same cycle: update wins, command register untouched
        send_cmd(16'hC000);
        p0 = rd_pulses;
        do_update(1'b1, 1'b0);
        repeat (4) @(posedge clk);
        chk("combined_fetch", 32'(rd_pulses - p0), 32'h1);
        do_update(1'b0, 1'b0);
        repeat (4) @(posedge clk);
        chk("cmd_kept_read", 32'(rd_pulses - p0), 32'h2);
        read_bits(TRACE_W, w);
        chk("word_0_again", 32'(w), 32'h13);

        // Hub deselect mid-word, then resume the remaining bits
        read_bits(3, w);
        jce2 = 1'b0;
        do_shift(1'b0, 1'b0, b);
        jce2 = 1'b1;
        ip_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_shift(1'b0, 1'b0, b);
            chk("disabled_tdo", 32'(b), 32'h0);
        end
        chk("disabled_addr", 32'(rd_addr), 32'h1);
        ip_enable = 1'b1;
        read_bits(3, w2);
        w[5:3] = w2[2:0];
        chk("word_1_split", 32'(w), 32'h2A);

        // Reset in the middle of a fetch
        send_cmd(16'hC000);
        do_update(1'b0, 1'b0);
        @(negedge clk);
        chk("fetch_rd_en", 32'(rd_en), 32'h1);
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midreset_rd_en", 32'(rd_en), 32'h0);
        chk("midreset_rd_addr", 32'(rd_addr), 32'h0);
        chk("midreset_underrun", 32'(underrun), 32'h0);
        chk("midreset_tdo", 32'(er2_tdo), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_en  = 1'b1;
        repeat (6) @(posedge clk);

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
